// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: default link timing,
// frame geometry and the arbiter state encoding.
package uart_pkg;

  // Default link timing; any transmitter sharing the arbiter must use the same values.
  localparam int DEFAULT_CLK_FREQ  = 50_000_000;
  localparam int DEFAULT_BAUD_RATE = 115_200;

  // One 8N1 frame on the wire: start bit, eight data bits, stop bit.
  localparam int FRAME_BITS = 10;

  // Arbiter states: IDLE accepts a grant, WAIT times out one frame plus guard.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

  // Width of an index into n requesters; a single requester still gets one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: finds the first asserted request at or
// after the pointer, wrapping modulo N, and reports it as index and one-hot.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]              req,
  input  logic [idx_width(N)-1:0]   ptr,
  output logic                      grant_valid,
  output logic [idx_width(N)-1:0]   grant_idx,
  output logic [N-1:0]              grant_onehot
);

  localparam int IDX_W = idx_width(N);

  // Scan the requesters in rotated order starting at the pointer; first hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves one
    // unassigned; an unassigned path in combinational logic infers a latch.
    int cand;
    grant_valid  = 1'b0;
    grant_idx    = '0;
    grant_onehot = '0;
    cand         = 0;
    for (int off = 0; off < N; off++) begin
      // NOTE: blocking assignments here, because later loop iterations must
      // see grant_valid as already updated by earlier ones in the same pass.
      cand = (int'(ptr) + off) % N;
      if (!grant_valid && req[cand]) begin
        grant_valid        = 1'b1;
        grant_idx          = IDX_W'(cand);
        grant_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter between N byte
// producers. The transmitter has no busy flag, so after each start pulse the
// arbiter blocks further grants for one frame time plus a guard interval.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N          = 4,
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
  parameter int GUARD_CLKS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             req,
  input  logic [8*N-1:0]           req_data,
  output logic [N-1:0]             ack,
  output logic [7:0]               tx_data,
  output logic                     tx_ready,
  output logic                     busy,
  output logic [idx_width(N)-1:0]  cur_src,
  output logic                     frame_done
);

  localparam int IDX_W        = idx_width(N);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int FRAME_CLKS   = FRAME_BITS * CLKS_PER_BIT + GUARD_CLKS;
  localparam int CNT_W        = $clog2(FRAME_CLKS + 1);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CLKS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  ptr_q;

  logic              grant_valid;
  logic [IDX_W-1:0]  grant_idx;
  logic [N-1:0]      grant_onehot;

  logic              grant_fire;
  logic              frame_end;
  logic [IDX_W-1:0]  next_ptr;
  logic [7:0]        granted_byte;

  uart_rr_pick #(
    .N (N)
  ) u_pick (
    .req          (req),
    .ptr          (ptr_q),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot)
  );

  // State register: IDLE after reset, abandoning any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a grant opens the wait window, the last count closes it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_valid)       state_d = WAIT;
      WAIT:    if (cnt_q == LAST_CNT) state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // Output decode: grant and frame-end strobes, pointer advance and the
  // winning byte. Only the granted lane reaches the mux output, so undriven
  // lanes of idle requesters never propagate.
  always_comb begin
    grant_fire   = (state_q == IDLE) && grant_valid;
    frame_end    = (state_q == WAIT) && (cnt_q == LAST_CNT);
    next_ptr     = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
    granted_byte = 8'h00;
    for (int i = 0; i < N; i++) begin
      if (grant_onehot[i]) begin
        granted_byte = req_data[8*i +: 8];
      end
    end
  end

  // Frame timer and round-robin pointer. The counter restarts on every grant,
  // so it never needs to wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      ptr_q <= '0;
    end else if (grant_fire) begin
      cnt_q <= '0;
      ptr_q <= next_ptr;
    end else if (frame_end) begin
      cnt_q <= '0;
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Registered outputs: single-cycle ack/start/done pulses, the latched byte
  // and source, and busy spanning the whole frame plus guard interval.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack        <= '0;
      tx_data    <= 8'h00;
      tx_ready   <= 1'b0;
      busy       <= 1'b0;
      cur_src    <= '0;
      frame_done <= 1'b0;
    end else begin
      ack        <= '0;
      tx_ready   <= 1'b0;
      frame_done <= 1'b0;
      if (grant_fire) begin
        ack      <= grant_onehot;
        tx_data  <= granted_byte;
        tx_ready <= 1'b1;
        busy     <= 1'b1;
        cur_src  <= grant_idx;
      end else if (frame_end) begin
        busy       <= 1'b0;
        frame_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios with literal
// expectations, a randomized phase checked every cycle against a timeline
// model, and a single-requester instance for back-to-back frames.
module tb_uart_tx_arbiter;

  localparam int N          = 4;
  localparam int FRAME_CLKS = 10 * (400 / 100) + 2;  // 42
  localparam int LIMIT      = 200;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   req = '0;
  logic [31:0]  req_data = '0;
  logic [3:0]   ack;
  logic [7:0]   tx_data;
  logic         tx_ready;
  logic         busy;
  logic [1:0]   cur_src;
  logic         frame_done;

  logic         req1 = 1'b0;
  logic [7:0]   req_data1 = '0;
  logic         ack1;
  logic [7:0]   tx_data1;
  logic         tx_ready1;
  logic         busy1;
  logic         cur_src1;
  logic         frame_done1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N(4), .CLK_FREQ(400), .BAUD_RATE(100), .GUARD_CLKS(2)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .tx_data(tx_data), .tx_ready(tx_ready), .busy(busy), .cur_src(cur_src),
    .frame_done(frame_done)
  );

  uart_tx_arbiter #(
    .N(1), .CLK_FREQ(400), .BAUD_RATE(100), .GUARD_CLKS(2)
  ) dut1 (
    .clk(clk), .rst(rst), .req(req1), .req_data(req_data1), .ack(ack1),
    .tx_data(tx_data1), .tx_ready(tx_ready1), .busy(busy1), .cur_src(cur_src1),
    .frame_done(frame_done1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Timeline reference model ----------------
  // A grant at edge g forbids grants until edge g+FRAME_CLKS+1 and schedules
  // frame_done on edge g+FRAME_CLKS; busy spans the edges in between.
  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int off = 0; off < N; off++) begin
      if (r[(p + off) % N]) return (p + off) % N;
    end
    return -1;
  endfunction

  int          m_edge;
  int          m_next_grant;
  int          m_done;
  int          m_ptr;
  logic [3:0]  e_ack;
  logic [7:0]  e_tx_data;
  logic        e_tx_ready;
  logic        e_busy;
  logic [1:0]  e_cur_src;
  logic        e_frame_done;

  // Reference model advance on each clock edge, cleared by reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_edge       <= 0;
      m_next_grant <= 0;
      m_done       <= -1;
      m_ptr        <= 0;
      e_ack        <= '0;
      e_tx_data    <= '0;
      e_tx_ready   <= 1'b0;
      e_busy       <= 1'b0;
      e_cur_src    <= '0;
      e_frame_done <= 1'b0;
    end else begin
      m_edge       <= m_edge + 1;
      e_ack        <= '0;
      e_tx_ready   <= 1'b0;
      e_frame_done <= 1'b0;
      if (m_edge + 1 == m_done) begin
        e_frame_done <= 1'b1;
        e_busy       <= 1'b0;
      end else if (m_edge + 1 >= m_next_grant && rr_pick(req, m_ptr) >= 0) begin
        e_ack        <= 4'b0001 << rr_pick(req, m_ptr);
        e_tx_data    <= req_data[8*rr_pick(req, m_ptr) +: 8];
        e_tx_ready   <= 1'b1;
        e_busy       <= 1'b1;
        e_cur_src    <= 2'(rr_pick(req, m_ptr));
        m_ptr        <= (rr_pick(req, m_ptr) + 1) % N;
        m_next_grant <= m_edge + 1 + FRAME_CLKS + 1;
        m_done       <= m_edge + 1 + FRAME_CLKS;
      end
    end
  end

  // Compare every DUT output against the model on the falling edge.
  always @(negedge clk) begin
    check("ack",        32'(ack),        32'(e_ack));
    check("tx_data",    32'(tx_data),    32'(e_tx_data));
    check("tx_ready",   32'(tx_ready),   32'(e_tx_ready));
    check("busy",       32'(busy),       32'(e_busy));
    check("cur_src",    32'(cur_src),    32'(e_cur_src));
    check("frame_done", 32'(frame_done), 32'(e_frame_done));
  end

  // ---------------- Directed helpers ----------------
  task automatic wait_grant(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!tx_ready && cyc < LIMIT);
    if (!tx_ready) check("grant_timeout", 32'(tx_ready), 32'd1);
  endtask

  // Waits for frame_done, counting any start pulses or acks seen meanwhile.
  task automatic wait_done(output int cyc, output int pulses);
    cyc = 0;
    pulses = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (tx_ready || ack != 4'b0000) pulses++;
    end while (!frame_done && cyc < LIMIT);
    if (!frame_done) check("done_timeout", 32'(frame_done), 32'd1);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- Stimulus ----------------
  initial begin
    int cyc;
    int pulses;
    logic [7:0] lanes [4];

    // Reset and idle state.
    step(3);
    rst = 1'b1;
    check("rst_ack",      32'(ack),      32'd0);
    check("rst_tx_data",  32'(tx_data),  32'h00);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_cur_src",  32'(cur_src),  32'd0);
    step(2);
    check("idle_no_grant", 32'(tx_ready), 32'd0);

    // Single byte from requester 2.
    req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    req      = 4'b0100;
    step(1);
    check("single_ack",      32'(ack),      32'h4);
    check("single_tx_ready", 32'(tx_ready), 32'd1);
    check("single_tx_data",  32'(tx_data),  32'hA5);
    check("single_cur_src",  32'(cur_src),  32'd2);
    check("single_busy",     32'(busy),     32'd1);
    req = 4'b0000;
    wait_done(cyc, pulses);
    check("single_done_delay", 32'(cyc),  32'(FRAME_CLKS));
    check("single_done_busy",  32'(busy), 32'd0);

    // Contention, interrupted by a reset mid-frame (pointer is 3 here).
    lanes    = '{8'h11, 8'h22, 8'h33, 8'h44};
    req_data = {lanes[3], lanes[2], lanes[1], lanes[0]};
    req      = 4'b1111;
    wait_grant(cyc);
    check("pre_reset_src", 32'(cur_src), 32'd3);
    step(20);
    rst = 1'b0;
    #1;
    check("midrst_ack",      32'(ack),      32'd0);
    check("midrst_tx_ready", 32'(tx_ready), 32'd0);
    check("midrst_busy",     32'(busy),     32'd0);
    check("midrst_cur_src",  32'(cur_src),  32'd0);
    step(1);
    rst = 1'b1;
    wait_grant(cyc);
    check("post_rst_first_src", 32'(cur_src), 32'd0);
    check("post_rst_first_dat", 32'(tx_data), 32'h11);
    for (int i = 1; i <= 4; i++) begin
      wait_grant(cyc);
      check("contention_spacing", 32'(cyc),     32'(FRAME_CLKS + 1));
      check("contention_src",     32'(cur_src), 32'(i % 4));
      check("contention_data",    32'(tx_data), 32'(lanes[i % 4]));
    end

    // Fairness: grant 2, then 0101 must wrap to 0 before 2 again.
    req = 4'b0100;
    wait_grant(cyc);
    check("fair_first", 32'(cur_src), 32'd2);
    req = 4'b0101;
    wait_grant(cyc);
    check("fair_wrap", 32'(cur_src), 32'd0);
    wait_grant(cyc);
    check("fair_then_2", 32'(cur_src), 32'd2);

    // Requests raised and dropped inside the wait window are ignored.
    req = 4'b0000;
    step(10);
    req = 4'b0010;
    step(20);
    req = 4'b0000;
    wait_done(cyc, pulses);
    check("blocked_no_pulses", 32'(pulses), 32'd0);
    check("blocked_busy_low",  32'(busy),   32'd0);
    step(2);
    check("blocked_stays_idle", 32'(busy), 32'd0);

    // Randomized traffic obeying the valid/ready requester protocol.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && ack[i]) begin
          req[i] = ($urandom_range(0, 3) != 0);
          req_data[8*i +: 8] = 8'($urandom);
        end else if (!req[i]) begin
          if ($urandom_range(0, 9) == 0) begin
            req[i] = 1'b1;
            req_data[8*i +: 8] = 8'($urandom);
          end
        end else if ($urandom_range(0, 199) == 0) begin
          req[i] = 1'b0;
        end
      end
      step(1);
    end
    req = 4'b0000;

    // Single requester, back-to-back frames with new data on ack.
    req_data1 = 8'h5A;
    req1      = 1'b1;
    cyc = 0;
    do begin step(1); cyc++; end while (!tx_ready1 && cyc < LIMIT);
    check("n1_first_ready", 32'(tx_ready1), 32'd1);
    check("n1_first_ack",   32'(ack1),      32'd1);
    check("n1_first_data",  32'(tx_data1),  32'h5A);
    req_data1 = 8'hC3;
    cyc = 0;
    do begin step(1); cyc++; end while (!tx_ready1 && cyc < LIMIT);
    check("n1_spacing",     32'(cyc),      32'(FRAME_CLKS + 1));
    check("n1_second_data", 32'(tx_data1), 32'hC3);
    check("n1_cur_src",     32'(cur_src1), 32'd0);
    req1 = 1'b0;
    cyc = 0;
    do begin step(1); cyc++; end while (!frame_done1 && cyc < LIMIT);
    check("n1_done", 32'(frame_done1), 32'd1);
    step(1);
    check("n1_idle_busy", 32'(busy1), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (`tx` module, 8N1) between N byte-producing requesters.
- Performs round-robin selection and latches the granted byte. Issues the transmitter's one-cycle `tx_ready` start pulse.
- The transmitter exposes no busy flag, so the block holds off further grants for a full frame time plus a guard interval.
- Sits between client logic (command responders, status reporters) and `tx`. Both share `clk`/`rst`.

Parameters:
- N, 4, number of requesters (1..8).
- CLK_FREQ, 50_000_000, clock frequency in Hz; must match the `tx` instance.
- BAUD_RATE, 115200, baud rate; must match the `tx` instance.
- GUARD_CLKS, 2, idle cycles added after each frame before the next grant.
- localparam CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer divide, 434 at defaults).
- localparam FRAME_CLKS = 10*CLKS_PER_BIT + GUARD_CLKS (4342 at defaults).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  N  per-requester "byte available", level.
- req_data  in  8*N  byte for requester i on bits [8i+7:8i]; stable while req[i]=1.
- ack  out  N  one-hot, one-cycle pulse: requester's byte accepted.
- tx_data  out  8  byte to `tx`, held stable until the next grant.
- tx_ready  out  1  one-cycle start pulse to `tx`.
- busy  out  1  high while a frame or guard interval is in progress.
- cur_src  out  clog2(N) (min 1)  index of the most recently granted requester.
- frame_done  out  1  one-cycle pulse when the frame plus guard time elapses.

Behaviour:
- Reset (rst=0, async) forces outputs to: ack=0, tx_data=8'h00, tx_ready=0, busy=0, cur_src=0, frame_done=0.
- Reset also clears state to IDLE, the round-robin pointer to 0 and the counter to 0. Reset mid-frame abandons the frame; `tx` is reset by the same signal.
- State IDLE, req==0: remain in IDLE; all pulses stay 0.
- State IDLE, req!=0 at edge k: select the first set bit at or after the pointer, wrapping modulo N.
- In that same edge k, for winner g:
  - tx_data <= req_data[g], ack[g] <= 1, tx_ready <= 1.
  - cur_src <= g, pointer <= (g+1) mod N, cnt <= 0, busy <= 1, state -> WAIT.
- Latency: ack and tx_ready are visible in the cycle after req is sampled, and are coincident.
- State WAIT: cnt increments each cycle; ack and tx_ready return to 0 after one cycle. Requests are ignored, with no ack.
- Leaving WAIT: when cnt == FRAME_CLKS-1, go to IDLE with busy <= 0, frame_done <= 1 (one cycle) and cnt <= 0.
- A new grant can occur on the edge following frame_done.
- Spacing: tx_ready pulses are at least FRAME_CLKS+1 cycles apart.
- Requester protocol: req[i] is valid/ready-style. The requester drops req or presents its next byte in the cycle after seeing ack[i].
  - If req stays high, it is treated as a new byte.
  - The round-robin pointer still lets other pending requesters win first.
- A req that drops before being granted is never acked; this is not an error.
- N=1: grants alternate with WAIT only; the pointer stays 0.
- Counter width is clog2(FRAME_CLKS+1). No arithmetic wrap is possible because cnt resets on each grant.
- X-safety: req_data lanes that are not granted are never sampled.

Decomposition:
- Shared package `uart_pkg`:
  - default CLK_FREQ and BAUD_RATE;
  - FRAME_BITS=10 (start + 8 data + stop);
  - state encoding IDLE/WAIT.
- One sub-module, `uart_rr_pick`: combinational round-robin picker.
  - Inputs: req[N], ptr.
  - Outputs: grant_valid, grant_idx, grant_onehot.
- The top level holds the FSM, counter, output registers and pointer.

Test Plan (override CLKS_PER_BIT=4 via CLK_FREQ=400, BAUD_RATE=100, GUARD_CLKS=2, so FRAME_CLKS=42; N=4):
- Reset: drive rst=0 mid-WAIT (cnt=20) with req=4'b1111.
  - Immediately: ack=0, tx_ready=0, busy=0, cur_src=0.
  - After rst=1, the first grant goes to requester 0.
- Single byte: req=4'b0100 with lane 2 = 8'hA5, sampled at edge k.
  - At k+1: ack=4'b0100, tx_ready=1, tx_data=8'hA5, cur_src=2, busy=1.
  - frame_done pulses 42 cycles later.
  - A looped-back `rx` reports rx_data=8'hA5.
- Contention: req=4'b1111 held high, lanes 0..3 = 8'h11, 8'h22, 8'h33, 8'h44.
  - Grant order is 0,1,2,3,0.
  - tx_ready pulses are exactly 43 cycles apart.
  - rx receives 11,22,33,44,11.
- Round-robin fairness: after granting 2, assert req=4'b0101; the next grant must be 0 (wrap), then 2.
- Blocked during WAIT: raise req[1] at cnt=10 and drop it at cnt=30.
  - No ack[1] is produced.
  - tx_ready does not fire.
  - The block is back in IDLE with busy=0 after frame_done.
- Back-to-back same source: N=1, req held high with data changing 8'h5A then 8'hC3 on ack.
  - Two frames are sent 43 cycles apart.
  - rx receives 5A then C3.
